// File: rtl/fp_norm_sched_pkg.sv
// Shared types and constants for the normalization scheduler.
// FSM state codes are fixed so that state dumps match the legacy encoding.
package fp_norm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENC   = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int unsigned NORM_POS_DEF = 26;

    // Largest biased exponent; a result at or above it is an overflow.
    function automatic int unsigned max_exp(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_norm_sched_penc32.sv
// 32-bit leading-one detector: Dout is the index of the highest set bit.
// Valid is low for an all-zero input.
module fp_norm_sched_penc32 (
    input  logic [31:0] Din,
    output logic [4:0]  Dout,
    output logic        Valid
);

    always_comb begin
        Dout  = '0;
        Valid = |Din;
        for (int unsigned i = 0; i < 32; i++) begin
            if (Din[i]) Dout = 5'(i);
        end
    end

endmodule

// File: rtl/fp_norm_sched.sv
// Round-robin normalization scheduler: one shared leading-one detector and
// a single registered barrel-shift stage serve NREQ add/sub lanes.
module fp_norm_sched
    import fp_norm_sched_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned EXP_W    = 8,
    parameter int unsigned NORM_POS = NORM_POS_DEF
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*32-1:0]    ReqMant,
    input  logic [NREQ*EXP_W-1:0] ReqExp,
    output logic [NREQ-1:0]       Gnt,
    output logic                  Busy,
    output logic                  Done,
    output logic [1:0]            RespId,
    output logic [31:0]           RespMant,
    output logic [EXP_W-1:0]      RespExp,
    output logic                  RespZero,
    output logic                  RespUflow,
    output logic                  RespOflow
);

    localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'(max_exp(EXP_W));

    state_t               state_q, state_d;
    logic [1:0]           rr_q, gidx, cand;
    logic                 found, take;
    logic [3:0]           req4;
    logic [31:0]          mant_arr [4];
    logic [EXP_W-1:0]     exp_arr  [4];

    logic [31:0]          mant_q;
    logic [EXP_W-1:0]     exp_q;
    logic [1:0]           id_q;
    logic [4:0]           penc_pos, pos_q;
    logic                 penc_valid, valid_q;

    int                   d;
    logic [4:0]           sh;
    logic [31:0]          lowmask;
    logic signed [EXP_W+1:0] e_ext, d_ext, e_new;
    logic [31:0]          n_mant;
    logic [EXP_W-1:0]     n_exp;
    logic                 n_zero, n_uf, n_of;

    // Lanes are padded to four so that a 2-bit index is always in range.
    always_comb begin
        req4 = '0;
        req4[NREQ-1:0] = Req;
        for (int unsigned k = 0; k < 4; k++) begin
            mant_arr[k] = '0;
            exp_arr[k]  = '0;
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            mant_arr[k] = ReqMant[32*k +: 32];
            exp_arr[k]  = ReqExp[EXP_W*k +: EXP_W];
        end

        // Descending scan so the candidate nearest rr+1 is the last writer.
        gidx  = rr_q;
        found = 1'b0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand = 2'((32'(rr_q) + k) % NREQ);
            if (req4[cand]) begin
                gidx  = cand;
                found = 1'b1;
            end
        end
        take = found && (state_q == IDLE) && !Rst;

        Gnt = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            Gnt[k] = take && (gidx == 2'(k));
        end

        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take) state_d = ENC;
            ENC:     state_d = SHIFT;
            SHIFT:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign Busy = (state_q != IDLE) || take;
    assign Done = (state_q == RESP);

    fp_norm_sched_penc32 u_penc (
        .Din   (mant_q),
        .Dout  (penc_pos),
        .Valid (penc_valid)
    );

    always_comb begin
        d       = int'(NORM_POS) - int'(pos_q);
        e_ext   = {2'b00, exp_q};
        d_ext   = (EXP_W+2)'(d);
        e_new   = e_ext;
        sh      = '0;
        lowmask = '0;
        n_mant  = mant_q;
        n_exp   = exp_q;
        n_zero  = 1'b0;
        n_uf    = 1'b0;
        n_of    = 1'b0;
        if (!valid_q) begin
            n_mant = '0;
            n_exp  = '0;
            n_zero = 1'b1;
        end else if (d < 0) begin
            sh      = 5'(-d);
            lowmask = ~(32'hFFFF_FFFF << sh);
            n_mant  = (mant_q >> sh) | {31'b0, |(mant_q & lowmask)};
            e_new   = e_ext - d_ext;
            if (e_new >= EMAX) begin
                n_mant = '0;
                n_exp  = '1;
                n_of   = 1'b1;
            end else begin
                n_exp = e_new[EXP_W-1:0];
            end
        end else if (d > 0) begin
            if (e_ext > d_ext) begin
                sh     = 5'(d);
                n_mant = mant_q << sh;
                e_new  = e_ext - d_ext;
                n_exp  = e_new[EXP_W-1:0];
            end else begin
                sh     = (e_ext > 0) ? 5'(e_ext - 1) : '0;
                n_mant = mant_q << sh;
                n_exp  = '0;
                n_uf   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            rr_q      <= 2'(NREQ - 1);
            mant_q    <= '0;
            exp_q     <= '0;
            id_q      <= '0;
            pos_q     <= '0;
            valid_q   <= 1'b0;
            RespId    <= '0;
            RespMant  <= '0;
            RespExp   <= '0;
            RespZero  <= 1'b0;
            RespUflow <= 1'b0;
            RespOflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                rr_q   <= gidx;
                id_q   <= gidx;
                mant_q <= mant_arr[gidx];
                exp_q  <= exp_arr[gidx];
            end
            if (state_q == ENC) begin
                pos_q   <= penc_pos;
                valid_q <= penc_valid;
            end
            if (state_q == SHIFT) begin
                RespId    <= id_q;
                RespMant  <= n_mant;
                RespExp   <= n_exp;
                RespZero  <= n_zero;
                RespUflow <= n_uf;
                RespOflow <= n_of;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_sched.sv
// Self-checking bench for fp_norm_sched: directed corner cases, random jobs
// against an arithmetic reference, round-robin order and mid-job reset.
module tb_fp_norm_sched;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [1:0]  Req;
    logic [63:0] ReqMant;
    logic [15:0] ReqExp;
    logic [1:0]  Gnt;
    logic        Busy, Done;
    logic [1:0]  RespId;
    logic [31:0] RespMant;
    logic [7:0]  RespExp;
    logic        RespZero, RespUflow, RespOflow;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0] m;
        logic [7:0]  e;
        logic        z;
        logic        u;
        logic        o;
    } res_t;

    fp_norm_sched #(.NREQ(2), .EXP_W(8), .NORM_POS(26)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Req       (Req),
        .ReqMant   (ReqMant),
        .ReqExp    (ReqExp),
        .Gnt       (Gnt),
        .Busy      (Busy),
        .Done      (Done),
        .RespId    (RespId),
        .RespMant  (RespMant),
        .RespExp   (RespExp),
        .RespZero  (RespZero),
        .RespUflow (RespUflow),
        .RespOflow (RespOflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Normalize so the leading one lands on bit 26, using plain arithmetic.
    function automatic res_t model(input logic [31:0] mant, input int ex);
        res_t   r;
        int     p;
        int     sft;
        longint lm;
        r = '0;
        if (mant == 32'd0) begin
            r.z = 1'b1;
            return r;
        end
        p = 31;
        while (mant[p] == 1'b0) p--;
        lm = longint'(mant);
        if (p > 26) begin
            sft = p - 26;
            r.m = 32'(lm / (64'sd1 << sft));
            if (lm % (64'sd1 << sft) != 0) r.m[0] = 1'b1;
            if (ex + sft >= 255) begin
                r.o = 1'b1;
                r.e = 8'hFF;
                r.m = '0;
            end else begin
                r.e = 8'(ex + sft);
            end
        end else if (p == 26) begin
            r.m = mant;
            r.e = 8'(ex);
        end else begin
            sft = 26 - p;
            if (ex > sft) begin
                r.m = 32'(lm * (64'sd1 << sft));
                r.e = 8'(ex - sft);
            end else begin
                r.u = 1'b1;
                r.m = 32'(lm * (64'sd1 << ((ex > 0) ? ex - 1 : 0)));
            end
        end
        return r;
    endfunction

    task automatic check_resp(input int lane, input res_t r);
        check("resp_id",    RespId,    lane);
        check("resp_mant",  RespMant,  r.m);
        check("resp_exp",   RespExp,   r.e);
        check("resp_zero",  RespZero,  r.z);
        check("resp_uflow", RespUflow, r.u);
        check("resp_oflow", RespOflow, r.o);
    endtask

    task automatic run_job(input int lane, input logic [31:0] m, input logic [7:0] e);
        res_t r;
        int   cyc;
        r = model(m, e);
        @(posedge Clk);
        #1;
        ReqMant[32*lane +: 32] = m;
        ReqExp[8*lane +: 8]    = e;
        Req[lane]              = 1'b1;
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (Gnt == 2'b00 && cyc < 20);
        check("gnt", Gnt, 32'd1 << lane);
        check("busy_gnt", Busy, 1);
        @(posedge Clk);
        #1 Req[lane] = 1'b0;
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (!Done && cyc < 10);
        check("latency", cyc, 3);
        check("busy_done", Busy, 1);
        check_resp(lane, r);
        @(negedge Clk);
        check("done_drop", Done, 0);
        check("hold_mant", RespMant, r.m);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_gnt"},  Gnt,       0);
        check({tag, "_busy"}, Busy,      0);
        check({tag, "_done"}, Done,      0);
        check({tag, "_id"},   RespId,    0);
        check({tag, "_mant"}, RespMant,  0);
        check({tag, "_exp"},  RespExp,   0);
        check({tag, "_flag"}, {29'd0, RespZero, RespUflow, RespOflow}, 0);
    endtask

    initial begin
        logic [31:0] m;
        int          sh;
        int          cyc;
        res_t        r0;

        Rst = 1'b1;
        Req = '0;
        ReqMant = '0;
        ReqExp = '0;
        repeat (2) @(posedge Clk);
        #1;
        check_idle_zero("reset");
        Req = 2'b11;
        #1;
        check("gnt_in_reset", Gnt, 0);
        Req = 2'b00;
        @(negedge Clk);
        Rst = 1'b0;

        run_job(0, 32'h0000_0400, 8'd100);
        run_job(0, 32'h0800_0001, 8'd50);
        run_job(1, 32'h0000_0010, 8'd5);
        run_job(0, 32'h0000_0000, 8'd77);
        run_job(1, 32'h8000_0000, 8'd250);
        run_job(0, 32'h0400_0000, 8'd9);
        run_job(1, 32'h0800_0000, 8'd254);
        run_job(0, 32'h0800_0000, 8'd253);
        run_job(1, 32'h0000_0001, 8'd0);
        run_job(0, 32'h0000_0001, 8'd26);

        for (int i = 0; i < 30; i++) begin
            sh = $urandom_range(0, 32);
            m  = (sh == 32) ? 32'd0 : ($urandom() >> sh);
            run_job($urandom_range(0, 1), m, 8'($urandom_range(0, 255)));
        end

        // Round-robin with both lanes held, then reset during a SHIFT.
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        ReqMant = {32'h00F0_0000, 32'h0000_1234};
        ReqExp  = {8'd30, 8'd120};
        Req     = 2'b11;
        for (int g = 0; g < 3; g++) begin
            cyc = 0;
            do begin
                @(negedge Clk);
                cyc++;
            end while (Gnt == 2'b00 && cyc < 20);
            check("rr_gnt", Gnt, (g % 2 == 0) ? 2'b01 : 2'b10);
            if (g > 0) check("rr_gap", cyc, 4);
        end
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        #1;
        check_idle_zero("midrst");
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("midrst_nodone", Done, 0);
        end
        Rst = 1'b0;
        #1;
        check("post_rst_gnt", Gnt, 2'b01);
        @(posedge Clk);
        #1 Req = 2'b00;
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (!Done && cyc < 10);
        check("post_rst_latency", cyc, 3);
        r0 = model(32'h0000_1234, 120);
        check_resp(0, r0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
